// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU operand loader.
//   state_e     - loader FSM state encoding (exposed on STATE for LEDG display)
//   OP_*        - the four legal ALU opcodes
//   is_legal_op - returns 1 when a 3-bit opcode is one of OP_*
package alu_pkg;

    typedef enum logic [1:0] {
        S_A     = 2'd0,
        S_B     = 2'd1,
        S_OP    = 2'd2,
        S_READY = 2'd3
    } state_e;

    localparam logic [2:0] OP_NOT = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b100;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op == OP_NOT) || (op == OP_AND) || (op == OP_OR) || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronizes the raw active-low pushbutton, optionally debounces it, and emits
// a single-cycle press pulse on each debounced 1->0 transition.
//   clk_i   - clock
//   rst_i   - asynchronous active-high reset
//   key_i   - raw active-low pushbutton
//   press_o - one-cycle pulse on a debounced press (releases produce nothing)
// Build option: define LOADER_DEBOUNCE_EN to compile in the DEBOUNCE_CYCLES stability filter;
// otherwise the synchronized key is used directly and DEBOUNCE_CYCLES is ignored.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_i,
    output logic press_o
);

    logic       key_meta_q, key_meta_d;
    logic       key_sync_q, key_sync_d;
    // Marks when key_sync_q holds a real sample rather than its reset value.
    logic [1:0] vld_q, vld_d;
    // Presses are only honoured after a released key has been seen since reset, so a key held
    // through reset cannot fire on reset release.
    logic       armed_q, armed_d;
    logic       db_prev_q, db_prev_d;
    logic       key_db;

`ifdef LOADER_DEBOUNCE_EN
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;

    // Count consecutive cycles the synchronized key disagrees with the accepted level; any
    // agreement (a bounce back) restarts the count.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (key_sync_q != db_q) begin
            if (cnt_q == CNT_MAX) begin
                db_d = key_sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            db_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    assign key_db = db_q;
`else
    assign key_db = key_sync_q;
`endif

    always_comb begin
        key_meta_d = key_i;
        key_sync_d = key_meta_q;
        vld_d      = {vld_q[0], 1'b1};
        armed_d    = armed_q | (vld_q[1] & key_sync_q & key_db);
        db_prev_d  = key_db;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
            vld_q      <= 2'b00;
            armed_q    <= 1'b0;
            db_prev_q  <= 1'b1;
        end else begin
            key_meta_q <= key_meta_d;
            key_sync_q <= key_sync_d;
            vld_q      <= vld_d;
            armed_q    <= armed_d;
            db_prev_q  <= db_prev_d;
        end
    end

    assign press_o = armed_q & db_prev_q & ~key_db;

endmodule

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: loads operand A, operand B and an ALU opcode from switches, one item per
// pushbutton press, cycling S_A -> S_B -> S_OP -> S_READY -> S_A.
//   CLOCK_50 - clock            RST   - asynchronous active-high reset
//   KEY      - raw active-low pushbutton
//   SW       - raw switch data (SW[2:0] supplies the opcode; WIDTH must be at least 3)
//   A, B     - registered operands        OPCODE - registered opcode
//   VALID    - A, B and OPCODE form a complete legal set
//   ERR      - one-cycle pulse when an illegal opcode capture is attempted
//   STATE    - current FSM state
// Build option: LOADER_DEBOUNCE_EN enables the key debounce filter (see key_debounce).
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned WIDTH           = 4
) (
    input  logic             CLOCK_50,
    input  logic             RST,
    input  logic             KEY,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [2:0]       OPCODE,
    output logic             VALID,
    output logic             ERR,
    output logic [1:0]       STATE
);

    logic             press;
    logic [WIDTH-1:0] sw_meta_q, sw_meta_d;
    logic [WIDTH-1:0] sw_sync_q, sw_sync_d;
    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk_i  (CLOCK_50),
        .rst_i  (RST),
        .key_i  (KEY),
        .press_o(press)
    );

    always_comb begin
        sw_meta_d = SW;
        sw_sync_d = sw_meta_q;
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        valid_d   = valid_q;
        err_d     = 1'b0;
        if (press) begin
            unique case (state_q)
                S_A: begin
                    a_d     = sw_sync_q;
                    state_d = S_B;
                end
                S_B: begin
                    b_d     = sw_sync_q;
                    state_d = S_OP;
                end
                S_OP: begin
                    if (is_legal_op(sw_sync_q[2:0])) begin
                        op_d    = sw_sync_q[2:0];
                        valid_d = 1'b1;
                        state_d = S_READY;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_READY: begin
                    valid_d = 1'b0;
                    state_d = S_A;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            state_q   <= S_A;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OP_NOT;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign A      = a_q;
    assign B      = b_q;
    assign OPCODE = op_q;
    assign VALID  = valid_q;
    assign ERR    = err_q;
    assign STATE  = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader with DEBOUNCE_CYCLES=4, WIDTH=4. Adapts its
// expected latencies to whether LOADER_DEBOUNCE_EN is defined.
module tb_alu_operand_loader;

    localparam int N = 4;
    localparam int W = 4;
`ifdef LOADER_DEBOUNCE_EN
    localparam int LAT      = 3 + N;
    localparam int PRESSES3 = 1;
`else
    localparam int LAT      = 3;
    localparam int PRESSES3 = 6;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         key = 1'b1;
    logic [W-1:0] sw  = '0;
    logic [W-1:0] a_o, b_o;
    logic [2:0]   op_o;
    logic         valid_o, err_o;
    logic [1:0]   state_o;

    always #5 clk = ~clk;

    alu_operand_loader #(
        .DEBOUNCE_CYCLES(N),
        .WIDTH          (W)
    ) dut (
        .CLOCK_50(clk),
        .RST     (rst),
        .KEY     (key),
        .SW      (sw),
        .A       (a_o),
        .B       (b_o),
        .OPCODE  (op_o),
        .VALID   (valid_o),
        .ERR     (err_o),
        .STATE   (state_o)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model, indexed by clock edge since reset release (index 0 = reset values).
    bit           k_smp[$];
    logic [W-1:0] sw_smp[$];
    bit           s_h[$];   // synchronized key level after each edge
    bit           db_h[$];  // accepted key level after each edge
    bit           m_armed, m_press;
    logic [W-1:0] m_swsync, m_a, m_b;
    logic [2:0]   m_op;
    logic         m_valid, m_err;
    logic [1:0]   m_state;
    int           err_seen, st_changes;
    logic [1:0]   last_state;

    task automatic model_reset();
        k_smp.delete(); sw_smp.delete(); s_h.delete(); db_h.delete();
        k_smp.push_back(1'b1); sw_smp.push_back('0);
        s_h.push_back(1'b1);   db_h.push_back(1'b1);
        m_armed = 0; m_press = 0; m_swsync = '0;
        m_a = '0; m_b = '0; m_op = 3'b000; m_valid = 0; m_err = 0; m_state = 2'd0;
    endtask

    task automatic model_step();
        int i;
        bit d, flip, s_new, db_new;
        m_err = 0;
        if (m_press) begin
            case (m_state)
                2'd0: begin m_a = m_swsync; m_state = 2'd1; end
                2'd1: begin m_b = m_swsync; m_state = 2'd2; end
                2'd2: begin
                    if (m_swsync[2:0] inside {3'b000, 3'b001, 3'b010, 3'b100}) begin
                        m_op = m_swsync[2:0]; m_valid = 1; m_state = 2'd3;
                    end else begin
                        m_err = 1;
                    end
                end
                default: begin m_valid = 0; m_state = 2'd0; end
            endcase
        end
        k_smp.push_back(key);
        sw_smp.push_back(sw);
        i = k_smp.size() - 1;
        s_new    = (i >= 2) ? k_smp[i-1] : 1'b1;
        m_swsync = (i >= 2) ? sw_smp[i-1] : '0;
        s_h.push_back(s_new);
        if (i - 1 >= 2 && s_h[i-1] && db_h[i-1]) m_armed = 1;
`ifdef LOADER_DEBOUNCE_EN
        // Level flips once the last N synchronized samples all disagree with it.
        d    = db_h[i-1];
        flip = (i >= N);
        for (int j = 1; j <= N; j++) if (i - j >= 0 && s_h[i-j] == d) flip = 0;
        db_new = flip ? ~d : d;
`else
        db_new = s_new;
`endif
        db_h.push_back(db_new);
        m_press = m_armed && db_h[i-1] && !db_new;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("outs", {17'd0, a_o, b_o, op_o, valid_o, err_o, state_o},
              {17'd0, m_a, m_b, m_op, m_valid, m_err, m_state});
        if (err_o === 1'b1) err_seen++;
        if (state_o !== last_state) st_changes++;
        last_state = state_o;
    endtask

    task automatic press_key();
        key = 1'b0; repeat (N + 6) tick();
        key = 1'b1; repeat (N + 6) tick();
    endtask

    task automatic measure_latency(input string tag);
        logic [1:0] s0;
        int lat;
        s0  = state_o;
        lat = 0;
        key = 1'b0;
        while (state_o === s0 && lat < 50) begin tick(); lat++; end
        check(tag, lat, LAT);
    endtask

    initial begin
        last_state = 2'd0;
        #1 rst = 1'b1;
        #1 check("reset_vals", {17'd0, a_o, b_o, op_o, valid_o, err_o, state_o}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        repeat (5) tick();

        // Test 1: load A, B, OPCODE
        sw = 4'b0110; press_key();
        sw = 4'b0101; press_key();
        sw = 4'b0001; press_key();
        check("t1_a", a_o, 4'b0110);
        check("t1_b", b_o, 4'b0101);
        check("t1_op", op_o, 3'b001);
        check("t1_valid", valid_o, 1'b1);
        check("t1_state", state_o, 2'd3);

        // Test 4: press in S_READY, then hold 100 cycles without auto-repeat
        key = 1'b0; repeat (N + 6) tick();
        check("t4_state", state_o, 2'd0);
        check("t4_valid", valid_o, 1'b0);
        check("t4_ab", {a_o, b_o}, 8'b0110_0101);
        repeat (100 - (N + 6)) tick();
        check("t4_hold_state", state_o, 2'd0);
        key = 1'b1; repeat (N + 6) tick();

        // Test 2: illegal opcode in S_OP
        sw = 4'b0010; press_key();
        sw = 4'b1011; press_key();
        sw = 4'b0011;
        err_seen = 0;
        press_key();
        check("t2_err_cycles", err_seen, 1);
        check("t2_state", state_o, 2'd2);
        check("t2_valid", valid_o, 1'b0);
        check("t2_op", op_o, 3'b001);

        // Test 3: bouncing key, then settle low
        sw = 4'b0001; repeat (N + 6) tick();
        st_changes = 0;
        for (int h = 0; h < 10; h++) begin
            key = (h % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) tick();
        end
        measure_latency("t3_latency");
        repeat (N + 6) tick();
        key = 1'b1; repeat (N + 6) tick();
        check("t3_presses", st_changes, PRESSES3);

        // Test 5: reset mid-count in S_B with key held low
        for (int n = 0; n < 8 && state_o !== 2'd1; n++) press_key();
        check("t5_in_sb", state_o, 2'd1);
        key = 1'b0; repeat (2) tick();
        rst = 1'b1;
        #1 check("t5_reset_vals", {17'd0, a_o, b_o, op_o, valid_o, err_o, state_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        last_state = state_o;
        repeat (100) tick();
        check("t5_no_press_held", state_o, 2'd0);
        key = 1'b1; repeat (N + 6) tick();
        press_key();
        check("t5_repress", state_o, 2'd1);

        // Test 6: clean-press latency from the KEY fall
        measure_latency("t6_latency");
        check("t6_state", state_o, 2'd2);
        repeat (N + 6) tick();
        key = 1'b1; repeat (N + 6) tick();

        // Randomized key patterns and switch values against the model
        for (int it = 0; it < 60; it++) begin
            sw  = W'($urandom);
            key = 1'b0; repeat ($urandom_range(1, 10)) tick();
            if ($urandom_range(0, 3) == 0) sw = W'($urandom);
            key = 1'b1; repeat ($urandom_range(1, 10)) tick();
        end
        repeat (N + 6) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_operand_loader.md
ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, SHALL set the cycles KEY must be stable before a level change is accepted (10 ms at 50 MHz).
REQ-002 Parameter WIDTH, default 4, SHALL set the operand width.
REQ-003 CLOCK_50  in  1  SHALL be the single clock; all state SHALL be rising-edge.
REQ-004 RST  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 KEY  in  1  SHALL be the raw active-low pushbutton; a press is 1->0.
REQ-006 SW  in  WIDTH  SHALL be the raw switch data to capture.
REQ-007 A  out  WIDTH  SHALL be the registered operand A.
REQ-008 B  out  WIDTH  SHALL be the registered operand B.
REQ-009 OPCODE  out  3  SHALL be the registered ALU opcode.
REQ-010 VALID  out  1  SHALL be high while A, B and OPCODE form a complete, legal set.
REQ-011 ERR  out  1  SHALL be a one-cycle pulse on an illegal opcode capture.
REQ-012 STATE  out  2  SHALL expose the FSM state, for LEDG display.

Function
REQ-013 KEY and SW SHALL each pass through a 2-flop synchronizer before any use.
REQ-014 A press SHALL generate exactly one 1-cycle PRESS pulse, on the cycle the debounced KEY level goes 1->0; releases SHALL generate nothing.
REQ-015 Debounced KEY SHALL change only after the synchronized KEY differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce SHALL restart the count.
REQ-016 FSM states SHALL be S_A=0, S_B=1, S_OP=2, S_READY=3.
REQ-017 In S_A, PRESS SHALL load A from the synchronized SW and move to S_B.
REQ-018 In S_B, PRESS SHALL load B and move to S_OP.
REQ-019 In S_OP, PRESS with SW[2:0] in {000,001,010,100} SHALL load OPCODE, set VALID and move to S_READY.
REQ-020 In S_OP, PRESS with any other SW[2:0] SHALL leave OPCODE unchanged, pulse ERR for one cycle and remain in S_OP.
REQ-021 In S_READY, PRESS SHALL clear VALID and move to S_A; A, B and OPCODE SHALL hold their values until reloaded.
REQ-022 Captured values and VALID SHALL appear on outputs the cycle after PRESS; there is no other latency.
REQ-023 Outside PRESS cycles, all outputs except ERR SHALL hold their values; SW changes SHALL have no effect.
REQ-024 Keys held longer than the debounce time SHALL not auto-repeat.

Reset
REQ-025 RST SHALL immediately force S_A, A=0, B=0, OPCODE=000, VALID=0, ERR=0, debounced KEY=1, debounce counter=0, and synchronizers=1 (KEY) / 0 (SW).
REQ-026 RST asserted mid-sequence or mid-debounce SHALL discard the partial entry, and no PRESS SHALL be generated on release of RST while KEY is held low until KEY is released and pressed again.

Configuration
REQ-027 With LOADER_DEBOUNCE_EN defined, the debounce filter of REQ-015 SHALL be compiled in.
REQ-028 Without LOADER_DEBOUNCE_EN, debounced KEY SHALL equal synchronized KEY, DEBOUNCE_CYCLES SHALL be ignored, and PRESS SHALL be a 1->0 edge of synchronized KEY.

Structure
REQ-029 Package alu_pkg SHALL hold the FSM state typedef/encoding, the opcode constants OP_NOT=000, OP_AND=001, OP_OR=010 and OP_XOR=100, and a function returning whether an opcode is legal.
REQ-030 Synchronizer, debounce and edge detect SHALL be sub-module key_debounce, instantiated once for KEY.

Verification (DEBOUNCE_CYCLES=4, LOADER_DEBOUNCE_EN defined unless noted)
REQ-031 Test 1: SW=0110 with a press; SW=0101 with a press; SW=0001 with a press -> A=0110, B=0101, OPCODE=001, VALID=1, STATE=3.
REQ-032 Test 2: in S_OP, SW=0011 with a press -> ERR high for exactly 1 cycle, STATE=2, VALID=0, OPCODE unchanged.
REQ-033 Test 3: KEY toggles every 2 cycles for 20 cycles, then settles low -> exactly one PRESS, 4 stable cycles plus synchronizer delay after the last edge.
REQ-034 Test 4: in S_READY, a press -> VALID=0 and STATE=0 next cycle, A and B unchanged; KEY held low for 100 cycles -> no further state change.
REQ-035 Test 5: RST pulsed mid-count in S_B with KEY held low -> all outputs at reset values immediately; no PRESS until KEY is released and pressed again.
REQ-036 Test 6: LOADER_DEBOUNCE_EN undefined; clean press -> state advances 3 cycles after the KEY fall (2 synchronizer stages + capture).
